// File: rtl/ttpu_pkg.sv
// Shared constants and types for the systolic matrix front end.
// Loader and timer agree on matrix geometry and sweep length through this package.
package ttpu_pkg;

    localparam int MAT_N      = 32;
    localparam int ELEM_W     = 16;
    localparam int RUN_CYCLES = 2 * MAT_N - 1;

    typedef logic [ELEM_W-1:0] elem_t;

    typedef enum logic [1:0] {
        CLEAR = 2'd0,
        LOAD  = 2'd1,
        RUN   = 2'd2,
        DONE  = 2'd3
    } loader_state_t;

endpackage

// File: rtl/matrix_loader.sv
// Streams an N x N matrix into a register buffer, then holds it steady while
// timer_en is asserted for one full diagonal sweep of the downstream timer.
//
// state | meaning
// CLEAR | zero the buffer, one cycle
// LOAD  | accept row-major words until last index or s_last
// RUN   | timer_en high for RUN_CYCLES cycles, buffer frozen
// DONE  | one idle cycle with done pulse so the timer can rearm
module matrix_loader
    import ttpu_pkg::*;
#(
    parameter int N          = MAT_N,
    parameter int W          = ELEM_W,
    parameter int RUN_CYCLES = 2 * N - 1
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        s_valid,
    output logic                        s_ready,
    input  logic [W-1:0]                s_data,
    input  logic                        s_last,
    output logic [N-1:0][N-1:0][W-1:0]  matrix_out,
    output logic                        timer_en,
    output logic                        busy,
    output logic                        done,
    output logic                        err_len
);

    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
    localparam int CNT_W = $clog2(RUN_CYCLES + 1);
    localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(N - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(RUN_CYCLES - 1);

    loader_state_t               r_state;
    logic [IDX_W-1:0]            r_row;
    logic [IDX_W-1:0]            r_col;
    logic [CNT_W-1:0]            r_run_cnt;
    logic                        r_done;
    logic                        r_err_len;
    logic [N-1:0][N-1:0][W-1:0]  r_mat;

    logic w_accept;
    logic w_last_k;
    logic w_first;
    logic w_len_err;
    logic w_exit;

    assign w_accept  = s_valid && (r_state == LOAD);
    assign w_last_k  = (r_row == IDX_MAX) && (r_col == IDX_MAX);
    assign w_first   = (r_row == '0) && (r_col == '0);
    // Length error: s_last arrives early, or the final index arrives without it.
    assign w_len_err = w_last_k ? !s_last : s_last;
    assign w_exit    = w_last_k || s_last;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= CLEAR;
            r_row     <= '0;
            r_col     <= '0;
            r_run_cnt <= '0;
            r_done    <= 1'b0;
            r_err_len <= 1'b0;
            r_mat     <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                CLEAR: begin
                    r_mat   <= '0;
                    r_row   <= '0;
                    r_col   <= '0;
                    r_state <= LOAD;
                end
                LOAD: begin
                    if (w_accept) begin
                        r_mat[r_row][r_col] <= s_data;
                        if (w_first) begin
                            r_err_len <= w_len_err;
                        end else if (w_len_err) begin
                            r_err_len <= 1'b1;
                        end
                        if (w_exit) begin
                            r_state   <= RUN;
                            r_row     <= '0;
                            r_col     <= '0;
                            r_run_cnt <= '0;
                        end else if (r_col == IDX_MAX) begin
                            r_col <= '0;
                            r_row <= r_row + 1'b1;
                        end else begin
                            r_col <= r_col + 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (r_run_cnt == CNT_MAX) begin
                        r_state <= DONE;
                        r_done  <= 1'b1;
                    end else begin
                        r_run_cnt <= r_run_cnt + 1'b1;
                    end
                end
                DONE: begin
                    r_state <= CLEAR;
                end
                default: begin
                    r_state <= CLEAR;
                end
            endcase
        end
    end

    assign s_ready    = (r_state == LOAD);
    assign timer_en   = (r_state == RUN);
    assign busy       = (r_state == RUN) || (r_state == DONE);
    assign done       = r_done;
    assign err_len    = r_err_len;
    assign matrix_out = r_mat;

endmodule

// File: doc/matrix_loader.md
Name: matrix_loader

Overview:
- Upstream feeder for matrix_timer.
- Accepts a streamed N x N matrix of W-bit words in row-major order over a valid/ready handshake, and stores it in a register buffer.
- Presents the buffer on matrix_out and drives timer_en for exactly the diagonal-sweep duration, so matrix_timer emits all 2N-1 skewed vectors into the systolic array.
- Refuses new input until the sweep completes.

Parameters:
- N, 32, matrix dimension (rows = cols).
- W, 16, element width in bits.
- RUN_CYCLES, 2*N-1 (63), cycles timer_en is held high per matrix.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- s_valid  in  1  upstream word valid.
- s_ready  out  1  loader can accept a word this cycle.
- s_data  in  W  matrix element, row-major: index k = row*N + col.
- s_last  in  1  marks the final element of a matrix.
- matrix_out  out  W x N x N  stored matrix, [row][col], drives matrix_timer.matrix_in.
- timer_en  out  1  drives matrix_timer.en.
- busy  out  1  high in RUN and DONE.
- done  out  1  one-cycle pulse after the sweep ends.
- err_len  out  1  sticky length-mismatch flag.

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low on rst_n.
- Reset values: state=CLEAR, all matrix_out=0, row=col=0, run_cnt=0, s_ready=0, timer_en=0, busy=0, done=0, err_len=0. Assertion mid-operation aborts immediately to these values.
- FSM states: CLEAR -> LOAD -> RUN -> DONE -> CLEAR.
- CLEAR (1 cycle):
  - Zero all N*N buffer entries.
  - s_ready=0.
  - Next state LOAD.
- LOAD:
  - s_ready=1. A word is accepted only on a clock edge where s_valid && s_ready.
  - On accept: buffer[row][col] <= s_data. col increments; at col=N-1 it wraps to 0 and row increments.
  - Accepting the first word of a matrix (row=col=0) clears err_len, unless that same word sets it.
  - Exit on the accepted word at k = N*N-1: go to RUN, run_cnt=0.
  - Exit on an accepted word with s_last=1 and k < N*N-1: go to RUN, set err_len. Unwritten entries stay 0 (cleared in CLEAR).
  - Word k = N*N-1 accepted with s_last=0: set err_len, still go to RUN.
- RUN:
  - s_ready=0, timer_en=1, busy=1.
  - run_cnt counts 0..RUN_CYCLES-1. On run_cnt = RUN_CYCLES-1, go to DONE.
  - timer_en is high for exactly RUN_CYCLES consecutive cycles, starting the cycle after the final word is accepted.
  - matrix_out is held constant for the whole of RUN.
- DONE (1 cycle):
  - timer_en=0, done=1, busy=1, s_ready=0.
  - Next state CLEAR.
  - The guaranteed low cycle lets matrix_timer reset its step counter.
- s_valid outside LOAD is ignored: no acceptance, no buffer write.
- Timing:
  - Minimum period per matrix: N*N load cycles + RUN_CYCLES + 1 (DONE) + 1 (CLEAR).
  - Gap from last accepted word to next s_ready=1 is RUN_CYCLES + 2 cycles.
- row/col counters are width clog2(N). run_cnt is width clog2(RUN_CYCLES+1). No overflow is reachable.
- All outputs are registered, except s_ready, timer_en and busy, which are decoded from state.

Decomposition:
- Shared package ttpu_pkg holds:
  - constants MAT_N=32, ELEM_W=16, RUN_CYCLES=2*MAT_N-1;
  - typedef elem_t (logic [ELEM_W-1:0]);
  - enum loader_state_t {CLEAR, LOAD, RUN, DONE}.
- No sub-module is required. The FSM, counters and buffer live in one module.
- The top level instantiates matrix_loader and connects matrix_out/timer_en to matrix_timer.

Test Plan:
- Full matrix: stream 1024 words, data = k, no stalls, s_last on k=1023.
  - Expect matrix_out[r][c] = r*32+c.
  - timer_en high for exactly 63 cycles, then done pulse.
  - err_len=0.
  - matrix_timer output at step 5, lane 2 = 2*32+3 = 67.
- Backpressure/gaps: toggle s_valid randomly at 50%.
  - Expect the same buffer contents as the full-matrix case.
  - Only edges with s_valid=1 advance the counters.
- Early s_last on k=99 (row 3, col 3).
  - Expect RUN entered the next cycle and err_len=1.
  - matrix_out[3][4] through [31][31] = 0.
- Missing s_last on k=1023.
  - Expect err_len=1 and a normal 63-cycle RUN.
  - Next matrix's first accepted word clears err_len.
- s_valid held high during RUN/DONE/CLEAR with data=16'hDEAD.
  - Expect s_ready=0 and no buffer change.
  - s_ready rises exactly 65 cycles after the last accepted word.
- rst_n low mid-LOAD (k=500) and again mid-RUN (run_cnt=30).
  - Expect immediate timer_en=0, busy=0 and matrix_out all 0.
  - After release: 1 CLEAR cycle, then s_ready=1.
